// File: rtl/noc_flit_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// noc_flit_transmitter_pkg
//   Shared definitions for the NoC flit transmitter slice:
//     - default flit width
//     - header field layout (destination in the top byte, length below it)
//     - transmitter FSM state encoding
// -----------------------------------------------------------------------------
package noc_flit_transmitter_pkg;

  // Default flit width used across the NoC.
  localparam int NOC_DATA_WIDTH = 32;

  // Destination field is {x[3:0], y[3:0]} and occupies the top byte of a header.
  localparam int HDR_DST_WIDTH = 8;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } tx_state_e;

  // LSB position of the destination field in a header of width data_width.
  function automatic int hdr_dst_lsb(input int data_width);
    return data_width - HDR_DST_WIDTH;
  endfunction

  // LSB position of the length field, which sits directly below the destination.
  function automatic int hdr_len_lsb(input int data_width, input int len_width);
    return data_width - HDR_DST_WIDTH - len_width;
  endfunction

endpackage : noc_flit_transmitter_pkg

// File: rtl/noc_flit_transmitter_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
//   Single-clock payload buffer for the flit transmitter. FIFO_DEPTH must be a
//   power of two so the read/write pointers wrap naturally.
//
//   Ports
//     clk         clock, rising edge
//     rst         asynchronous active-high reset (empties the buffer)
//     push_valid  write request
//     push_ready  buffer not full
//     push_data   write data
//     pop         read request (ignored while empty)
//     pop_data    data at the head of the buffer
//     empty       buffer holds no entries
//
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is dropped. push_ready reflects "not full" only, so it does
//   not depend combinationally on the pop side.
// -----------------------------------------------------------------------------
module noc_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic full;
  logic do_push;
  logic do_pop;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign push_ready = !full;

  assign do_pop  = pop && !empty;
  // A full buffer can still take a write when an entry leaves in the same cycle.
  assign do_push = push_valid && (!full || do_pop);

  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count/pointers alone,
  // which keeps the array in plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : noc_sync_fifo

// File: rtl/noc_flit_transmitter.sv
// -----------------------------------------------------------------------------
// noc_flit_transmitter
//   Packetises a request (destination + payload length) and buffered payload
//   flits into a header flit followed by len body flits toward a router
//   receive port. One packet is in flight at a time.
//
//   Ports
//     noc_clk       clock, rising edge
//     rst           asynchronous active-high reset
//     req_valid     packet request valid
//     req_ready     request accepted when req_valid && req_ready
//     req_dst       destination {x[3:0], y[3:0]}
//     req_len       number of payload flits (0 = header-only packet)
//     pl_valid      payload write valid
//     pl_ready      payload buffer not full
//     pl_data       payload flit
//     tx_valid      flit valid toward router
//     tx_ready      router accepts the flit
//     tx_flit       flit data
//     tx_VCready    downstream VC can accept a new packet (gates the header only)
//     tx_is_header  current flit is the header
//     tx_is_tail    current flit is the tail
//
//   Header layout: [DATA_WIDTH-1 -: 8] = dst, next LEN_WIDTH bits = len,
//   remaining low bits zero. Requires DATA_WIDTH >= 8 + LEN_WIDTH.
// -----------------------------------------------------------------------------
module noc_flit_transmitter
  import noc_flit_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  noc_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_dst,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [DATA_WIDTH-1:0] pl_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_flit,
  input  logic                  tx_VCready,
  output logic                  tx_is_header,
  output logic                  tx_is_tail
);

  localparam int DST_LSB = hdr_dst_lsb(DATA_WIDTH);
  localparam int LEN_LSB = hdr_len_lsb(DATA_WIDTH, LEN_WIDTH);

  tx_state_e state;
  tx_state_e state_next;

  logic [HDR_DST_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     remaining;

  logic                  req_fire;
  logic                  load_remaining;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] header_flit;

  // ---------------------------------------------------------------------------
  // Payload buffer: writable in every FSM state, drained only in BODY.
  // ---------------------------------------------------------------------------
  noc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_payload_fifo (
    .clk        (noc_clk),
    .rst        (rst),
    .push_valid (pl_valid),
    .push_ready (pl_ready),
    .push_data  (pl_data),
    .pop        (fifo_pop),
    .pop_data   (fifo_head),
    .empty      (fifo_empty)
  );

  // The FSM already sits in IDLE during reset, so req_ready is also masked by
  // rst itself; it rises as soon as reset is released.
  assign req_ready = (state == IDLE) && !rst;
  assign req_fire  = req_valid && req_ready;

  // Header is built from the latched request so it stays stable while stalled.
  always_comb begin
    header_flit                             = '0;
    header_flit[DST_LSB +: HDR_DST_WIDTH]   = dst_q;
    header_flit[LEN_LSB +: LEN_WIDTH]       = len_q;
  end

  // ---------------------------------------------------------------------------
  // State and request registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dst_q     <= '0;
      len_q     <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        dst_q <= req_dst;
        len_q <= req_len;
      end
      if (load_remaining) begin
        remaining <= len_q;
      end else if (fifo_pop) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next     = state;
    load_remaining = 1'b0;
    fifo_pop       = 1'b0;
    tx_valid       = 1'b0;
    tx_flit        = '0;
    tx_is_header   = 1'b0;
    tx_is_tail     = 1'b0;

    case (state)
      IDLE: begin
        if (req_fire) begin
          state_next = HEAD;
        end
      end

      HEAD: begin
        // Only the header waits for VC credit; body flits follow regardless.
        tx_valid     = tx_VCready;
        tx_flit      = header_flit;
        tx_is_header = 1'b1;
        tx_is_tail   = (len_q == '0);
        if (tx_VCready && tx_ready) begin
          load_remaining = 1'b1;
          state_next     = (len_q == '0) ? IDLE : BODY;
        end
      end

      BODY: begin
        tx_valid   = !fifo_empty;
        tx_flit    = fifo_empty ? '0 : fifo_head;
        tx_is_tail = (remaining == LEN_WIDTH'(1));
        if (!fifo_empty && tx_ready) begin
          fifo_pop = 1'b1;
          if (remaining == LEN_WIDTH'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : noc_flit_transmitter
